// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - read, writeback, issue and status signals of reg_file_sb
interface reg_file_sb_if #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NUM_RD*AW-1:0]   rs_i;
  logic [NUM_RD*XLEN-1:0] rs_d_o;
  logic [NUM_RD-1:0]      hazard_o;
  logic                   we_i;
  logic [AW-1:0]          rd_i;
  logic [XLEN-1:0]        rf_wd_i;
  logic                   issue_i;
  logic [AW-1:0]          issue_rd_i;
  logic                   busy_o;

  modport master (
    output rs_i, we_i, rd_i, rf_wd_i, issue_i, issue_rd_i,
    input  rs_d_o, hazard_o, busy_o
  );

  modport slave (
    input  rs_i, we_i, rd_i, rf_wd_i, issue_i, issue_rd_i,
    output rs_d_o, hazard_o, busy_o
  );
endinterface

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with bypass, post-reset clear and RAW scoreboard
module reg_file_sb #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int NUM_RD  = 2,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  reg_file_sb_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic {CLEAR, READY} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [NREGS-1:0]  pend_q, pend_d;
  logic [XLEN-1:0]   mem [NREGS];

  logic ready, zr, byp, wr_ok, iss_ok;

  assign zr     = (ZERO_R0 != 0);
  assign byp    = (BYPASS != 0);
  assign ready  = (state_q == READY);
  assign wr_ok  = ready && bus.we_i && !(zr && bus.rd_i == '0);
  assign iss_ok = ready && bus.issue_i && !(zr && bus.issue_rd_i == '0);
  assign bus.busy_o = !ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLEAR;
      idx_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == CLEAR) begin
      idx_d = idx_q + AW'(1);
      if (idx_q == AW'(NREGS - 1)) begin
        state_d = READY;
      end
    end
  end

  // Clear before set so a same-edge issue to the written register stays pending.
  always_comb begin
    pend_d = pend_q;
    if (wr_ok) begin
      pend_d[bus.rd_i] = 1'b0;
    end
    if (iss_ok) begin
      pend_d[bus.issue_rd_i] = 1'b1;
    end
  end

  // Array has no reset; the clear sequence zeroes it once reset is released.
  always_ff @(posedge clk_i) begin
    if (rst_ni && state_q == CLEAR) begin
      mem[idx_q] <= '0;
    end else if (wr_ok) begin
      mem[bus.rd_i] <= bus.rf_wd_i;
    end
  end

  always_comb begin
    logic [AW-1:0] a;
    logic          fwd;
    a            = '0;
    fwd          = 1'b0;
    bus.rs_d_o   = '0;
    bus.hazard_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      a   = bus.rs_i[k*AW +: AW];
      fwd = byp && wr_ok && (bus.rd_i == a);
      if (ready && !(zr && a == '0)) begin
        bus.rs_d_o[k*XLEN +: XLEN] = fwd ? bus.rf_wd_i : mem[a];
        bus.hazard_o[k]            = pend_q[a] && !fwd;
      end
    end
  end
endmodule
